// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM bus arbiter: FSM states, owner encoding, streak width.
// Pure declarations, no logic.
// Imported by sram_bus_arbiter and sram_arb_sel.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam int STREAK_W = 3;

endpackage

// File: rtl/sram_arb_sel.sv
// Grant selection between inst and data requesters; data wins unless ARB_FAIR_EN forces inst.
// Latency: combinational grants; streak counter (ARB_FAIR_EN only) updates on idle cycles.
// Backpressure: grants only while idle is high; the loser simply sees no grant.
module sram_arb_sel
    import sram_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

    logic force_inst;

`ifdef ARB_FAIR_EN
    logic [STREAK_W-1:0] streak;

    assign force_inst = (streak >= STREAK_W'(MAX_DATA_STREAK));

    // Counts data grants that made a waiting inst requester lose; saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (idle) begin
            if (grant_inst || !inst_req) begin
                streak <= '0;
            end else if (grant_data && (streak != '1)) begin
                streak <= streak + 1'b1;
            end
        end
    end
`else
    logic unused_sel;

    assign force_inst = 1'b0;
    assign unused_sel = clk ^ reset ^ (MAX_DATA_STREAK != 0);
`endif

    assign grant_data = idle & data_req & ~(force_inst & inst_req);
    assign grant_inst = idle & inst_req & (~data_req | force_inst);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between inst fetch and data requesters; optional ARB_FAIR_EN fairness.
// Latency: addr_ok combinational in IDLE; data_ok no earlier than the cycle after the grant.
// Backpressure: one transaction outstanding; requesters hold req until their addr_ok.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state, state_next;
    logic   owner;
    logic   idle, grant_inst, grant_data, resp_done;

    // Gating with reset keeps every ok output low while reset is asserted.
    assign idle = (state == IDLE) && !reset;

    sram_arb_sel #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_sel (
        .clk        (clk),
        .reset      (reset),
        .idle       (idle),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    assign resp_done = ((state == REQ) && mem_addr_ok && mem_data_ok) ||
                       ((state == RESP) && mem_data_ok);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_inst || grant_data) state_next = REQ;
            REQ:     if (mem_addr_ok) state_next = mem_data_ok ? IDLE : RESP;
            RESP:    if (mem_data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_DATA;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_data) begin
            owner     <= OWN_DATA;
            mem_req   <= 1'b1;
            mem_wr    <= data_wr;
            mem_wstrb <= data_wr ? data_wstrb : 4'b0;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
        end else if (grant_inst) begin
            owner     <= OWN_INST;
            mem_req   <= 1'b1;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'b0;
            mem_addr  <= inst_addr;
            mem_wdata <= '0;
        end else if ((state == REQ) && mem_addr_ok) begin
            mem_req <= 1'b0;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp_done && (owner == OWN_INST);
    assign data_data_ok = resp_done && (owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the IF instruction-fetch requester and the EX/MEM data requester.
- Data wins by default.
- Only one transaction is outstanding at a time.
- Uses a request/addr_ok/data_ok split handshake on both sides.
- Sits between the pipeline stages and the external memory bridge, replacing the separate inst/data SRAM ports.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while inst waits (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- inst_req  in  1  instruction read request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  request accepted
- inst_data_ok  out  1  read data valid, one-cycle pulse
- inst_rdata  out  DATA_W  read data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables for writes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  request accepted
- data_data_ok  out  1  read data valid / write done, one-cycle pulse
- data_rdata  out  DATA_W  read data
- mem_req  out  1  memory request
- mem_wr  out  1  write flag
- mem_wstrb  out  4  byte enables (0 for reads)
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  memory accepted the request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- States: IDLE, REQ, RESP. Owner register: INST or DATA.
- IDLE:
  - If data_req, grant DATA; else if inst_req, grant INST.
  - The winner's addr_ok is asserted combinationally in the same cycle.
  - The winner's fields are latched into mem_wr, mem_wstrb, mem_addr and mem_wdata; the owner is latched; next state is REQ.
  - An inst grant latches wr=0 and wstrb=0.
  - The loser's addr_ok stays 0 and the loser keeps its request held.
- REQ:
  - mem_req=1 and all mem_* fields are stable.
  - On mem_addr_ok: go to RESP.
  - If mem_data_ok is also high in the same cycle: pulse the owner's data_ok and go directly to IDLE.
  - mem_data_ok without mem_addr_ok is ignored.
- RESP:
  - mem_req=0.
  - On mem_data_ok: the owner's *_data_ok = 1 for that cycle and the next state is IDLE.
  - The non-owner's data_ok is never asserted.
- Read data: inst_rdata and data_rdata are both driven combinationally from mem_rdata; consumers qualify with data_ok.
- Writes also wait for mem_data_ok before completing.
- Latency: minimum 2 cycles from grant to data_ok (grant, REQ accepted together with data_ok). Throughput is one transaction per 2 cycles at best.
- No new grant while in REQ or RESP. *_addr_ok is 0 outside IDLE.
- Reset (asynchronous, any time):
  - State returns to IDLE and the owner to DATA.
  - mem_req, mem_wr, mem_wstrb, mem_addr and mem_wdata all go to 0.
  - All addr_ok and data_ok outputs are 0.
  - The streak counter is cleared.
  - Any in-flight transaction is abandoned; the memory side must be reset together with this block.
- mem_req is registered; addr_ok and data_ok are combinational.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - A 3-bit saturating streak counter increments on each DATA grant made while inst_req=1.
  - It clears on any INST grant, and on any IDLE cycle where inst_req=0.
  - When the count reaches MAX_DATA_STREAK and both requesters are pending, INST is granted.
- Undefined: strict data priority; the counter is absent.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum: IDLE=2'd0, REQ=2'd1, RESP=2'd2;
  - the owner encoding: OWN_INST=1'b0, OWN_DATA=1'b1;
  - STREAK_W=3.
- One sub-module, sram_arb_sel: combinational grant selection plus the optional streak counter. Its outputs are grant_inst and grant_data.

Test Plan:
- Single inst read: inst_req, addr 0x1C000000; memory gives addr_ok after 1 cycle, data_ok 2 cycles later with 0x02800C0C -> inst_addr_ok in the IDLE cycle; inst_data_ok pulses once with inst_rdata=0x02800C0C; data_data_ok stays 0.
- Simultaneous requests: inst_req and data_req (read, addr 0x1000) in the same cycle -> data granted first and mem_addr=0x1000; inst granted only after data_data_ok, with mem_addr=inst_addr.
- Data write: data_wr=1, wstrb=4'b0011, wdata=0xDEADBEEF, addr 0x2004 -> mem_wr=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF held through REQ; data_data_ok pulses on mem_data_ok.
- Same-cycle handshake: mem_addr_ok and mem_data_ok both high in REQ -> owner's data_ok pulses in that cycle and state returns to IDLE next cycle.
- Reset in RESP: assert reset while waiting for data_ok -> mem_req=0 and all ok outputs 0 immediately; after release a new inst_req is granted normally.
- ARB_FAIR_EN: data_req and inst_req held continuously -> 4 data grants, then 1 inst grant, repeating; without the macro, inst is never granted.
